// File: rtl/pe_stream_driver_pkg.sv
// Shared constants and FSM encoding for the serial_pe stream driver.
package pe_stream_driver_pkg;

    localparam int PE_LINE_W    = 512;
    localparam int PE_ELEM_W    = 16;
    localparam int PE_ELEMS     = 32;
    localparam int PE_IDX_W     = 5;
    localparam int PE_CTL_FIRST = 0;
    localparam int PE_CTL_LAST  = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_STREAM = 2'd3
    } pe_state_t;

endpackage

// File: rtl/pe_stream_driver_line_ser.sv
// One 512-bit line register plus an element selector; element 0 is the most
// significant 16 bits of the line.
module pe_stream_driver_line_ser
    import pe_stream_driver_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [PE_LINE_W-1:0] din,
    input  logic [PE_IDX_W-1:0]  idx,
    output logic [PE_ELEM_W-1:0] dout
);

    logic [PE_LINE_W-1:0] line_q;
    logic [PE_LINE_W-1:0] line_d;

    // Capture a new line on the load strobe, otherwise hold.
    always_comb begin
        line_d = line_q;
        if (load) begin
            line_d = din;
        end
    end

    // Line storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    // MSB-first element select with constant slice bounds.
    always_comb begin
        dout = '0;
        for (int k = 0; k < PE_ELEMS; k++) begin
            if (idx == PE_IDX_W'(k)) begin
                dout = line_q[PE_ELEM_W*(PE_ELEMS-1-k) +: PE_ELEM_W];
            end
        end
    end

endmodule

// File: rtl/pe_stream_driver.sv
// Job-driven initiator for serial_pe: fetches neuron/weight lines and streams
// them element by element with first/last markers.
// Optional build macro PE_STREAM_PERF_EN adds perf_jobs/perf_elems counters.
//
// state  | meaning
// IDLE   | ready for a descriptor
// FETCH  | first line read strobe on the SRAM ports
// LOAD   | SRAM data returning, captured at the end of this cycle
// STREAM | one element per cycle, next line prefetched at elem 30
module pe_stream_driver
    import pe_stream_driver_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inst_vld,
    output logic                 inst_rdy,
    input  logic [LEN_W-1:0]     inst_len,
    input  logic [ADDR_W-1:0]    inst_nbase,
    input  logic [ADDR_W-1:0]    inst_wbase,
    output logic                 nrn_rd_en,
    output logic [ADDR_W-1:0]    nrn_rd_addr,
    input  logic [PE_LINE_W-1:0] nrn_rd_data,
    output logic                 wgt_rd_en,
    output logic [ADDR_W-1:0]    wgt_rd_addr,
    input  logic [PE_LINE_W-1:0] wgt_rd_data,
    output logic [PE_ELEM_W-1:0] pe_neuron,
    output logic [PE_ELEM_W-1:0] pe_weight,
    output logic [1:0]           pe_ctl,
    output logic                 pe_vld,
    output logic                 busy,
    output logic                 job_done,
    output logic                 len_err
`ifdef PE_STREAM_PERF_EN
    ,
    output logic [31:0]          perf_jobs,
    output logic [31:0]          perf_elems
`endif
);

    pe_state_t             state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [ADDR_W-1:0]     nbase_q, nbase_d;
    logic [ADDR_W-1:0]     wbase_q, wbase_d;
    logic [LEN_W-1:0]      line_q, line_d;
    logic [PE_IDX_W-1:0]   elem_q, elem_d;
    logic [PE_IDX_W-1:0]   sel_q, sel_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]     nrn_addr_q, nrn_addr_d;
    logic [ADDR_W-1:0]     wgt_addr_q, wgt_addr_d;
    logic                  pe_vld_q, pe_vld_d;
    logic [1:0]            pe_ctl_q, pe_ctl_d;
    logic                  job_done_q, job_done_d;
    logic                  len_err_q, len_err_d;
    logic                  line_load;
    logic                  last_line;
    logic [LEN_W-1:0]      line_nxt;

    assign last_line = (line_q == len_q - LEN_W'(1));
    assign line_nxt  = line_q + LEN_W'(1);

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        nbase_d    = nbase_q;
        wbase_d    = wbase_q;
        line_d     = line_q;
        elem_d     = elem_q;
        sel_d      = sel_q;
        rd_en_d    = 1'b0;
        nrn_addr_d = nrn_addr_q;
        wgt_addr_d = wgt_addr_q;
        pe_vld_d   = 1'b0;
        pe_ctl_d   = 2'b00;
        job_done_d = 1'b0;
        len_err_d  = 1'b0;
        line_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inst_vld) begin
                    if (inst_len == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        len_d      = inst_len;
                        nbase_d    = inst_nbase;
                        wbase_d    = inst_wbase;
                        line_d     = '0;
                        elem_d     = '0;
                        rd_en_d    = 1'b1;
                        nrn_addr_d = inst_nbase;
                        wgt_addr_d = inst_wbase;
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                line_load             = 1'b1;
                elem_d                = '0;
                sel_d                 = '0;
                pe_vld_d              = 1'b1;
                pe_ctl_d[PE_CTL_FIRST] = 1'b1;
                state_d               = ST_STREAM;
            end
            ST_STREAM: begin
                if (elem_q == PE_IDX_W'(PE_ELEMS-1)) begin
                    if (last_line) begin
                        state_d = ST_IDLE;
                    end else begin
                        line_load = 1'b1;
                        line_d    = line_nxt;
                        elem_d    = '0;
                        sel_d     = '0;
                        pe_vld_d  = 1'b1;
                    end
                end else begin
                    elem_d   = elem_q + PE_IDX_W'(1);
                    sel_d    = elem_q + PE_IDX_W'(1);
                    pe_vld_d = 1'b1;
                    if (last_line && elem_q == PE_IDX_W'(PE_ELEMS-2)) begin
                        pe_ctl_d[PE_CTL_LAST] = 1'b1;
                        job_done_d            = 1'b1;
                    end
                end
                // Strobe registered here so it is visible during elem 30 and the
                // data arrives in time for the load at the end of elem 31.
                if (!last_line && elem_q == PE_IDX_W'(PE_ELEMS-3)) begin
                    rd_en_d    = 1'b1;
                    nrn_addr_d = nbase_q + ADDR_W'(line_nxt);
                    wgt_addr_d = wbase_q + ADDR_W'(line_nxt);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, job context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            nbase_q    <= '0;
            wbase_q    <= '0;
            line_q     <= '0;
            elem_q     <= '0;
            sel_q      <= '0;
            rd_en_q    <= 1'b0;
            nrn_addr_q <= '0;
            wgt_addr_q <= '0;
            pe_vld_q   <= 1'b0;
            pe_ctl_q   <= 2'b00;
            job_done_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            nbase_q    <= nbase_d;
            wbase_q    <= wbase_d;
            line_q     <= line_d;
            elem_q     <= elem_d;
            sel_q      <= sel_d;
            rd_en_q    <= rd_en_d;
            nrn_addr_q <= nrn_addr_d;
            wgt_addr_q <= wgt_addr_d;
            pe_vld_q   <= pe_vld_d;
            pe_ctl_q   <= pe_ctl_d;
            job_done_q <= job_done_d;
            len_err_q  <= len_err_d;
        end
    end

    pe_stream_driver_line_ser u_nrn_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (line_load),
        .din   (nrn_rd_data),
        .idx   (sel_q),
        .dout  (pe_neuron)
    );

    pe_stream_driver_line_ser u_wgt_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (line_load),
        .din   (wgt_rd_data),
        .idx   (sel_q),
        .dout  (pe_weight)
    );

    assign inst_rdy    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign nrn_rd_en   = rd_en_q;
    assign wgt_rd_en   = rd_en_q;
    assign nrn_rd_addr = nrn_addr_q;
    assign wgt_rd_addr = wgt_addr_q;
    assign pe_vld      = pe_vld_q;
    assign pe_ctl      = pe_ctl_q;
    assign job_done    = job_done_q;
    assign len_err     = len_err_q;

`ifdef PE_STREAM_PERF_EN
    logic [31:0] perf_jobs_q, perf_jobs_d;
    logic [31:0] perf_elems_q, perf_elems_d;

    // Free-running job and element counters, wrapping naturally.
    always_comb begin
        perf_jobs_d  = perf_jobs_q;
        perf_elems_d = perf_elems_q;
        if (job_done_q) begin
            perf_jobs_d = perf_jobs_q + 32'd1;
        end
        if (pe_vld_q) begin
            perf_elems_d = perf_elems_q + 32'd1;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_jobs_q  <= '0;
            perf_elems_q <= '0;
        end else begin
            perf_jobs_q  <= perf_jobs_d;
            perf_elems_q <= perf_elems_d;
        end
    end

    assign perf_jobs  = perf_jobs_q;
    assign perf_elems = perf_elems_q;
`endif

endmodule

// File: tb/tb_pe_stream_driver.sv
// Directed self-checking bench for pe_stream_driver with a 1-cycle SRAM model.
module tb_pe_stream_driver;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inst_vld;
    logic         inst_rdy;
    logic [7:0]   inst_len;
    logic [15:0]  inst_nbase;
    logic [15:0]  inst_wbase;
    logic         nrn_rd_en;
    logic [15:0]  nrn_rd_addr;
    logic [511:0] nrn_rd_data;
    logic         wgt_rd_en;
    logic [15:0]  wgt_rd_addr;
    logic [511:0] wgt_rd_data;
    logic [15:0]  pe_neuron;
    logic [15:0]  pe_weight;
    logic [1:0]   pe_ctl;
    logic         pe_vld;
    logic         busy;
    logic         job_done;
    logic         len_err;
`ifdef PE_STREAM_PERF_EN
    logic [31:0]  perf_jobs;
    logic [31:0]  perf_elems;
`endif

    int checks = 0;
    int errors = 0;

    pe_stream_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_vld    (inst_vld),
        .inst_rdy    (inst_rdy),
        .inst_len    (inst_len),
        .inst_nbase  (inst_nbase),
        .inst_wbase  (inst_wbase),
        .nrn_rd_en   (nrn_rd_en),
        .nrn_rd_addr (nrn_rd_addr),
        .nrn_rd_data (nrn_rd_data),
        .wgt_rd_en   (wgt_rd_en),
        .wgt_rd_addr (wgt_rd_addr),
        .wgt_rd_data (wgt_rd_data),
        .pe_neuron   (pe_neuron),
        .pe_weight   (pe_weight),
        .pe_ctl      (pe_ctl),
        .pe_vld      (pe_vld),
        .busy        (busy),
        .job_done    (job_done),
        .len_err     (len_err)
`ifdef PE_STREAM_PERF_EN
        ,
        .perf_jobs   (perf_jobs),
        .perf_elems  (perf_elems)
`endif
    );

    always #5 clk = ~clk;

    // Element k of a line: address fingerprint, port flag, element number.
    function automatic logic [15:0] elem_of(input logic [15:0] a, input logic w, input int k);
        return {a[7:0] ^ a[15:8], w, 2'b01, 5'(k)};
    endfunction

    function automatic logic [511:0] line_of(input logic [15:0] a, input logic w);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 32; k++) begin
            l[16*(31-k) +: 16] = elem_of(a, w, k);
        end
        return l;
    endfunction

    // SRAM model: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (nrn_rd_en) nrn_rd_data <= line_of(nrn_rd_addr, 1'b0);
        if (wgt_rd_en) wgt_rd_data <= line_of(wgt_rd_addr, 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; inst_vld = 1'b0; inst_len = '0; inst_nbase = '0; inst_wbase = '0;
        nrn_rd_data = '0; wgt_rd_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({inst_rdy, busy, pe_vld, pe_ctl, job_done, len_err, nrn_rd_en, wgt_rd_en} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 100000000",
                     {inst_rdy, busy, pe_vld, pe_ctl, job_done, len_err, nrn_rd_en, wgt_rd_en});
        end
        checks++;
        if ({nrn_rd_addr, wgt_rd_addr, pe_neuron, pe_weight} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {nrn_rd_addr, wgt_rd_addr, pe_neuron, pe_weight});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({inst_rdy, busy, pe_vld} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release got %b want 100", {inst_rdy, busy, pe_vld});
        end
    endtask

    task automatic test_single();
        logic [37:0] act, exp;
        inst_vld = 1'b1; inst_len = 8'd1; inst_nbase = 16'h0000; inst_wbase = 16'h0000;
        @(negedge clk);
        inst_vld = 1'b0;
        checks++;
        if ({nrn_rd_en, wgt_rd_en, nrn_rd_addr, wgt_rd_addr, pe_vld, busy, inst_rdy} !== {2'b11, 32'h0, 3'b010}) begin
            errors++;
            $display("FAIL single_fetch got %h want %h",
                     {nrn_rd_en, wgt_rd_en, nrn_rd_addr, wgt_rd_addr, pe_vld, busy, inst_rdy}, {2'b11, 32'h0, 3'b010});
        end
        @(negedge clk);
        checks++;
        if ({pe_vld, nrn_rd_en, busy} !== 3'b001) begin
            errors++;
            $display("FAIL single_load got %b want 001", {pe_vld, nrn_rd_en, busy});
        end
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            act = {pe_vld, pe_ctl, job_done, pe_neuron, pe_weight, nrn_rd_en, wgt_rd_en};
            exp = {1'b1, k == 31, k == 0, k == 31, elem_of(16'h0, 1'b0, k), elem_of(16'h0, 1'b1, k), 2'b00};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL single_elem k=%0d got %h want %h", k, act, exp);
            end
            @(negedge clk);
        end
        exp = {1'b0, 2'b00, 1'b0, elem_of(16'h0, 1'b0, 31), elem_of(16'h0, 1'b1, 31), 2'b00};
        act = {pe_vld, pe_ctl, job_done, pe_neuron, pe_weight, nrn_rd_en, wgt_rd_en};
        checks++;
        if (act !== exp || inst_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after got %h rdy=%b busy=%b want %h rdy=1 busy=0", act, inst_rdy, busy, exp);
        end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int j = 0; j < 4; j++) begin
                    inst_vld = 1'b1; inst_len = 8'd4;
                    inst_nbase = 16'(4*j); inst_wbase = 16'(16'h0100 + 4*j);
                    for (int t = 0; t < 400; t++) begin
                        if (inst_rdy) break;
                        @(negedge clk);
                    end
                    @(negedge clk);
                end
                inst_vld = 1'b0;
            end
            begin
                logic [37:0] act, exp;
                logic [15:0] nb, wb;
                int gap;
                for (int j = 0; j < 4; j++) begin
                    nb = 16'(4*j); wb = 16'(16'h0100 + 4*j);
                    gap = 0;
                    while (pe_vld !== 1'b1 && gap < 50) begin
                        @(negedge clk);
                        gap++;
                    end
                    checks++;
                    if (gap != 3) begin
                        errors++;
                        $display("FAIL b2b_gap job=%0d got %0d want 3", j, gap);
                    end
                    for (int ln = 0; ln < 4; ln++) begin
                        for (int k = 0; k < 32; k++) begin
                            act = {pe_vld, pe_ctl, job_done, pe_neuron, pe_weight, nrn_rd_en, wgt_rd_en};
                            exp = {1'b1, ln == 3 && k == 31, ln == 0 && k == 0, ln == 3 && k == 31,
                                   elem_of(nb + 16'(ln), 1'b0, k), elem_of(wb + 16'(ln), 1'b1, k),
                                   ln < 3 && k == 30, ln < 3 && k == 30};
                            checks++;
                            if (act !== exp) begin
                                errors++;
                                $display("FAIL b2b_elem job=%0d line=%0d k=%0d got %h want %h", j, ln, k, act, exp);
                            end
                            if (ln < 3 && k == 30) begin
                                checks++;
                                if ({nrn_rd_addr, wgt_rd_addr} !== {nb + 16'(ln + 1), wb + 16'(ln + 1)}) begin
                                    errors++;
                                    $display("FAIL b2b_addr job=%0d line=%0d got %h want %h", j, ln,
                                             {nrn_rd_addr, wgt_rd_addr}, {nb + 16'(ln + 1), wb + 16'(ln + 1)});
                                end
                            end
                            @(negedge clk);
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_wrap();
        logic [37:0] act, exp;
        logic [15:0] na;
        inst_vld = 1'b1; inst_len = 8'd2; inst_nbase = 16'hFFFF; inst_wbase = 16'h0200;
        @(negedge clk);
        inst_vld = 1'b0;
        checks++;
        if ({nrn_rd_en, nrn_rd_addr} !== {1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL wrap_addr0 got %b/%h want 1/ffff", nrn_rd_en, nrn_rd_addr);
        end
        repeat (2) @(negedge clk);
        for (int ln = 0; ln < 2; ln++) begin
            na = (ln == 0) ? 16'hFFFF : 16'h0000;
            for (int k = 0; k < 32; k++) begin
                act = {pe_vld, pe_ctl, job_done, pe_neuron, pe_weight, nrn_rd_en, wgt_rd_en};
                exp = {1'b1, ln == 1 && k == 31, ln == 0 && k == 0, ln == 1 && k == 31,
                       elem_of(na, 1'b0, k), elem_of(16'(16'h0200 + ln), 1'b1, k),
                       ln == 0 && k == 30, ln == 0 && k == 30};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL wrap_elem line=%0d k=%0d got %h want %h", ln, k, act, exp);
                end
                if (ln == 0 && k == 30) begin
                    checks++;
                    if ({nrn_rd_addr, wgt_rd_addr} !== 32'h0000_0201) begin
                        errors++;
                        $display("FAIL wrap_addr1 got %h want 00000201", {nrn_rd_addr, wgt_rd_addr});
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_len0();
        inst_vld = 1'b1; inst_len = 8'd0; inst_nbase = 16'h0033; inst_wbase = 16'h0044;
        @(negedge clk);
        inst_vld = 1'b0;
        checks++;
        if ({len_err, busy, inst_rdy, nrn_rd_en, pe_vld} !== 5'b10100) begin
            errors++;
            $display("FAIL len0_pulse got %b want 10100", {len_err, busy, inst_rdy, nrn_rd_en, pe_vld});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({len_err, busy, nrn_rd_en, wgt_rd_en, pe_vld} !== 5'b00000) begin
                errors++;
                $display("FAIL len0_idle c=%0d got %b want 00000", c, {len_err, busy, nrn_rd_en, wgt_rd_en, pe_vld});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [37:0] act, exp;
        inst_vld = 1'b1; inst_len = 8'd3; inst_nbase = 16'h0040; inst_wbase = 16'h0080;
        @(negedge clk);
        inst_vld = 1'b0;
        repeat (44) @(negedge clk);
        checks++;
        if ({pe_vld, pe_neuron, pe_weight} !== {1'b1, elem_of(16'h0041, 1'b0, 10), elem_of(16'h0081, 1'b1, 10)}) begin
            errors++;
            $display("FAIL rstmid_pos got %h want %h", {pe_vld, pe_neuron, pe_weight},
                     {1'b1, elem_of(16'h0041, 1'b0, 10), elem_of(16'h0081, 1'b1, 10)});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({pe_vld, job_done, busy, inst_rdy, pe_ctl} !== 6'b000100) begin
            errors++;
            $display("FAIL rstmid_abort got %b want 000100", {pe_vld, job_done, busy, inst_rdy, pe_ctl});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({pe_vld, job_done, busy} !== 3'b000) begin
                errors++;
                $display("FAIL rstmid_quiet c=%0d got %b want 000", c, {pe_vld, job_done, busy});
            end
        end
        inst_vld = 1'b1; inst_len = 8'd1; inst_nbase = 16'h0005; inst_wbase = 16'h0006;
        @(negedge clk);
        inst_vld = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            act = {pe_vld, pe_ctl, job_done, pe_neuron, pe_weight, nrn_rd_en, wgt_rd_en};
            exp = {1'b1, k == 31, k == 0, k == 31, elem_of(16'h5, 1'b0, k), elem_of(16'h6, 1'b1, k), 2'b00};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL rstmid_next k=%0d got %h want %h", k, act, exp);
            end
            @(negedge clk);
        end
    endtask

`ifdef PE_STREAM_PERF_EN
    task automatic test_perf();
        int t;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({perf_jobs, perf_elems} !== 64'h0) begin
            errors++;
            $display("FAIL perf_reset got %0d/%0d want 0/0", perf_jobs, perf_elems);
        end
        for (int j = 0; j < 2; j++) begin
            inst_vld = 1'b1; inst_len = 8'(2 + j); inst_nbase = 16'(10*j); inst_wbase = 16'h0300;
            @(negedge clk);
            inst_vld = 1'b0;
            t = 0;
            while (inst_rdy !== 1'b1 && t < 300) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (t >= 300) begin
                errors++;
                $display("FAIL perf_wait job=%0d got timeout want idle", j);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (perf_jobs !== 32'd2 || perf_elems !== 32'd160) begin
            errors++;
            $display("FAIL perf_counts got %0d/%0d want 2/160", perf_jobs, perf_elems);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_wrap();
        repeat (2) @(negedge clk);
        test_len0();
        test_reset_mid();
        repeat (2) @(negedge clk);
`ifdef PE_STREAM_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
